// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//   Purpose : Central stall/flush sequencer for the 5-stage pipeline. Drives the
//             write-enable and bubble controls of the PC, IF/ID, ID/EX, EX/MEM
//             and MEM/WB registers, resolving load-use hazards, taken-branch
//             flushes and multi-cycle data-memory accesses (req/ack) with a
//             timeout that parks the pipeline in a sticky error state.
//   Ports   : clk_i, rst_i (async, active-low)
//             ID hazard inputs : IFID_RS1addr_i/IFID_RS2addr_i, IFID_RS1use_i/IFID_RS2use_i
//             EX hazard inputs : IDEX_MemRead_i, IDEX_RDaddr_i
//             Branch_taken_i   : branch resolved taken in ID
//             MEM stage        : EXMEM_MemRead_i, EXMEM_MemWrite_i, dmem_req_o, dmem_ack_i
//             Controls out     : PC_we_o, IFID_we_o, IFID_flush_o, IDEX_bubble_o,
//                                EXMEM_we_o, MEMWB_bubble_o
//             Status out       : mem_timeout_o (sticky), stall_cycles_o, flush_count_o
//   Option  : define PIPE_PERF_CNT_EN to build the saturating stall/flush
//             performance counters; otherwise both counter outputs are tied to 0.
// -----------------------------------------------------------------------------
// Sequencer for pipeline register enables/bubbles.
// Latency: controls are combinational from state + inputs; timeout flag registered.
// Backpressure: a pending memory access (no ack) freezes PC..EX/MEM until ack or timeout.
module pipeline_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  IFID_RS1addr_i,
    input  logic [4:0]  IFID_RS2addr_i,
    input  logic        IFID_RS1use_i,
    input  logic        IFID_RS2use_i,
    input  logic        IDEX_MemRead_i,
    input  logic [4:0]  IDEX_RDaddr_i,
    input  logic        Branch_taken_i,
    input  logic        EXMEM_MemRead_i,
    input  logic        EXMEM_MemWrite_i,
    output logic        dmem_req_o,
    input  logic        dmem_ack_i,
    output logic        PC_we_o,
    output logic        IFID_we_o,
    output logic        IFID_flush_o,
    output logic        IDEX_bubble_o,
    output logic        EXMEM_we_o,
    output logic        MEMWB_bubble_o,
    output logic        mem_timeout_o,
    output logic [31:0] stall_cycles_o,
    output logic [15:0] flush_count_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MWAIT = 2'd1,
        ST_ERR   = 2'd2
    } state_e;

    // Last wait-counter value tolerated in MWAIT before giving up.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;

    logic mem;
    logic load_use;

    // Internal (pre-reset-gating) control values.
    logic req;
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_we;
    logic memwb_bubble;
    logic mem_stall;

    assign mem = EXMEM_MemRead_i | EXMEM_MemWrite_i;

    // rd==x0 never creates a real dependency, so it must not stall.
    assign load_use = IDEX_MemRead_i && (IDEX_RDaddr_i != 5'd0) &&
                      ((IFID_RS1use_i && (IFID_RS1addr_i == IDEX_RDaddr_i)) ||
                       (IFID_RS2use_i && (IFID_RS2addr_i == IDEX_RDaddr_i)));

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and controls
    // -------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = timeout_q;
        mem_stall    = 1'b0;
        req          = 1'b0;
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_we     = 1'b1;
        memwb_bubble = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                req        = mem;
                wait_cnt_d = '0;
                // A zero-wait access (ack with req) costs no cycle.
                if (mem && !dmem_ack_i) begin
                    mem_stall = 1'b1;
                    state_d   = ST_MWAIT;
                end
            end
            ST_MWAIT: begin
                req = mem;
                if (dmem_ack_i) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d   = ST_ERR;
                        timeout_d = 1'b1;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                // ST_ERR: frozen with bubbles until reset.
                state_d = ST_ERR;
            end
        endcase

        if (state_q == ST_ERR) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            exmem_we     = 1'b0;
            idex_bubble  = 1'b1;
            memwb_bubble = 1'b1;
        end else if (mem_stall) begin
            // Freeze everything up to EX/MEM; ID/EX holds its content (no
            // bubble) because its enable is implied by the frozen upstream.
            // MEM/WB takes a bubble so the held MEM instruction is not
            // written back twice.
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            exmem_we     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (load_use) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end else if (Branch_taken_i) begin
            // A branch suppressed by a higher-priority stall stays in ID and
            // is seen again next cycle, so no memory of it is needed here.
            ifid_flush = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: held in the safe reset pattern while rst_i is low.
    // -------------------------------------------------------------------------
    assign dmem_req_o     = rst_i & req;
    assign PC_we_o        = rst_i & pc_we;
    assign IFID_we_o      = rst_i & ifid_we;
    assign IFID_flush_o   = rst_i & ifid_flush;
    assign IDEX_bubble_o  = ~rst_i | idex_bubble;
    assign EXMEM_we_o     = rst_i & exmem_we;
    assign MEMWB_bubble_o = ~rst_i | memwb_bubble;
    assign mem_timeout_o  = timeout_q;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // Saturating counters; pc_we/ifid_flush are only sampled out of reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_we && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (ifid_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cycles_o = stall_cnt_q;
    assign flush_count_o  = flush_cnt_q;
`else
    assign stall_cycles_o = '0;
    assign flush_count_o  = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the sequencing rules.
module tb_pipeline_ctrl;

    localparam int T_OUT = 4;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, idex_mr, br, mr, mw, ack;
    logic        dmem_req_o, PC_we_o, IFID_we_o, IFID_flush_o;
    logic        IDEX_bubble_o, EXMEM_we_o, MEMWB_bubble_o, mem_timeout_o;
    logic [31:0] stall_cycles_o;
    logic [15:0] flush_count_o;

    int n_checks = 0;
    int n_fails  = 0;

    // Model state: stall cycles spent on the current memory access, error flag,
    // and perf-counter expectations.
    int          m_waited;
    bit          m_err;
    logic [31:0] m_stall;
    logic [15:0] m_flush;

    pipeline_ctrl #(.MEM_TIMEOUT(T_OUT), .CNT_W(8)) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_n),
        .IFID_RS1addr_i   (rs1),
        .IFID_RS2addr_i   (rs2),
        .IFID_RS1use_i    (u1),
        .IFID_RS2use_i    (u2),
        .IDEX_MemRead_i   (idex_mr),
        .IDEX_RDaddr_i    (rd),
        .Branch_taken_i   (br),
        .EXMEM_MemRead_i  (mr),
        .EXMEM_MemWrite_i (mw),
        .dmem_req_o       (dmem_req_o),
        .dmem_ack_i       (ack),
        .PC_we_o          (PC_we_o),
        .IFID_we_o        (IFID_we_o),
        .IFID_flush_o     (IFID_flush_o),
        .IDEX_bubble_o    (IDEX_bubble_o),
        .EXMEM_we_o       (EXMEM_we_o),
        .MEMWB_bubble_o   (MEMWB_bubble_o),
        .mem_timeout_o    (mem_timeout_o),
        .stall_cycles_o   (stall_cycles_o),
        .flush_count_o    (flush_count_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Output vector order: {req, PC_we, IFID_we, IFID_flush, IDEX_bubble, EXMEM_we, MEMWB_bubble, timeout}
    function automatic logic [7:0] exp_ctrl();
        logic mem, lu;
        mem = mr | mw;
        lu  = idex_mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (!rst_n)                              return 8'b0000_1010;
        if (m_err)                               return 8'b0000_1011;
        if (!ack && (mem || m_waited > 0))       return 8'b1000_0010;
        if (lu)                                  return {mem, 7'b000_1100};
        if (br)                                  return {mem, 7'b111_0100};
        return {mem, 7'b110_0100};
    endfunction

    function automatic logic [31:0] exp_stall();
`ifdef PIPE_PERF_CNT_EN
        return rst_n ? m_stall : 32'd0;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [15:0] exp_flush();
`ifdef PIPE_PERF_CNT_EN
        return rst_n ? m_flush : 16'd0;
`else
        return 16'd0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_update(input logic [7:0] e);
        if (!rst_n) begin
            m_err = 1'b0; m_waited = 0; m_stall = '0; m_flush = '0;
        end else begin
            if (!e[6] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (e[4] && m_flush != 16'hFFFF)       m_flush = m_flush + 1;
            if (!m_err) begin
                if (!ack && ((mr | mw) || m_waited > 0)) begin
                    m_waited++;
                    if (m_waited == T_OUT + 1) m_err = 1'b1;
                end else begin
                    m_waited = 0;
                end
            end
        end
    endtask

    // Inputs are set at the falling edge before calling; outputs are checked
    // mid-low-phase, then the model advances with the rising edge.
    task automatic step(input string tag);
        logic [7:0] e;
        e = exp_ctrl();
        #2;
        check({tag, "/ctrl"},
              32'({dmem_req_o, PC_we_o, IFID_we_o, IFID_flush_o,
                   IDEX_bubble_o, EXMEM_we_o, MEMWB_bubble_o, mem_timeout_o}), 32'(e));
        check({tag, "/stall_cnt"}, stall_cycles_o, exp_stall());
        check({tag, "/flush_cnt"}, 32'(flush_count_o), 32'(exp_flush()));
        @(posedge clk_i);
        model_update(e);
        @(negedge clk_i);
    endtask

    task automatic clear_inputs();
        rs1 = 0; rs2 = 0; rd = 0; u1 = 0; u2 = 0; idex_mr = 0;
        br = 0; mr = 0; mw = 0; ack = 0;
    endtask

    initial begin
        m_waited = 0; m_err = 0; m_stall = '0; m_flush = '0;
        clear_inputs();
        rst_n = 1'b0;
        @(negedge clk_i);
        step("reset0");
        step("reset1");
        rst_n = 1'b1;

        // Idle pipeline
        for (int i = 0; i < 10; i++) step("idle");

        // Load-use on rs2, then same pattern with rd = x0
        idex_mr = 1; rd = 5; rs2 = 5; u2 = 1;
        step("loaduse");
        clear_inputs();
        step("loaduse_after");
        idex_mr = 1; rd = 0; rs2 = 0; u2 = 1;
        step("loaduse_x0");
        clear_inputs();

        // Store waits three cycles, acked on the fourth
        mw = 1;
        for (int i = 0; i < 3; i++) step("store_wait");
        ack = 1;
        step("store_ack");
        clear_inputs();
        step("store_after");
`ifdef PIPE_PERF_CNT_EN
        check("perf_stall_4", stall_cycles_o, 32'd4);
`endif

        // Branch flush, then a branch hidden by load-use and retried
        br = 1;
        step("branch");
        clear_inputs();
        step("branch_after");
`ifdef PIPE_PERF_CNT_EN
        check("perf_flush_1", 32'(flush_count_o), 32'd1);
`endif
        br = 1; idex_mr = 1; rd = 7; rs1 = 7; u1 = 1;
        step("branch_vs_loaduse");
        idex_mr = 0;
        step("branch_retry");
        clear_inputs();

        // Zero-wait access: ack together with request
        mr = 1; ack = 1;
        step("load_zero_wait");
        clear_inputs();

        // Load never acked: timeout into ERR, late ack ignored, reset exits
        mr = 1;
        for (int i = 0; i < T_OUT + 1; i++) step("load_timeout");
        for (int i = 0; i < 3; i++) step("err_hold");
        ack = 1;
        step("err_late_ack");
        ack = 0;
        rst_n = 1'b0;
        step("err_reset");
        rst_n = 1'b1; mr = 0;
        step("post_reset");
        step("post_reset_idle");

        // Random traffic; memory inputs held steady while an access is pending
        for (int i = 0; i < 600; i++) begin
            rst_n   = ($urandom_range(0, 79) != 0);
            rs1     = 5'($urandom_range(0, 3));
            rs2     = 5'($urandom_range(0, 3));
            rd      = 5'($urandom_range(0, 3));
            u1      = 1'($urandom_range(0, 1));
            u2      = 1'($urandom_range(0, 1));
            idex_mr = ($urandom_range(0, 2) == 0);
            br      = ($urandom_range(0, 3) == 0);
            if (m_waited == 0) begin
                mr = ($urandom_range(0, 3) == 0);
                mw = !mr && ($urandom_range(0, 4) == 0);
            end
            ack     = ($urandom_range(0, 2) != 0);
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
